// File: rtl/cache_line_burst_adapter_if.sv
// Cache-side and memory-side signal bundle of the line/word burst adapter.
// The adapter takes the slave view; the cache/memory environment takes master.
interface cache_line_burst_adapter_if #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 8,
  parameter int ADDR_W = 32
) ();
  localparam int LINE_W = WORD_W * WORDS;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] wb_addr;
  logic [LINE_W-1:0] c_line_i;
  logic              cl_read;
  logic              cl_write;
  logic [WORD_W-1:0] m_rdata;
  logic              m_ack;
  logic [ADDR_W-1:0] m_addr;
  logic [WORD_W-1:0] m_wdata;
  logic              m_we;
  logic              m_re;
  logic [LINE_W-1:0] c_line_o;
  logic              cl_busy;
  logic              cl_done;

  modport slave (
    input  addr, wb_addr, c_line_i,
    input  cl_read, cl_write,
    input  m_rdata, m_ack,
    output m_addr, m_wdata, m_we, m_re,
    output c_line_o, cl_busy, cl_done
  );

  modport master (
    output addr, wb_addr, c_line_i,
    output cl_read, cl_write,
    output m_rdata, m_ack,
    input  m_addr, m_wdata, m_we, m_re,
    input  c_line_o, cl_busy, cl_done
  );
endinterface

// File: rtl/cache_line_burst_adapter.sv
// Line-to-word burst bridge: serialises writebacks, deserialises fills,
// and chains writeback-then-fill for dirty evictions.
module cache_line_burst_adapter #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 8,
  parameter int ADDR_W = 32
) (
  input logic                       CLK,
  input logic                       RST_N,
  cache_line_burst_adapter_if.slave bus
);
  localparam int BYTES = WORD_W / 8;
  localparam int OFF   = $clog2(WORDS * BYTES);
  localparam int BSH   = $clog2(BYTES);
  localparam int CNT_W = (WORDS > 2) ? $clog2(WORDS) : 1;

  localparam logic [CNT_W-1:0]  LAST = CNT_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] MASK =
    {{(ADDR_W - OFF){1'b1}}, {OFF{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic [CNT_W-1:0]             r_cnt;
  logic [WORDS-1:0][WORD_W-1:0] r_wbuf;
  logic [WORDS-1:0][WORD_W-1:0] r_line;
  logic [ADDR_W-1:0]            r_wb_base;
  logic [ADDR_W-1:0]            r_rd_base;
  logic                         r_pend;
  logic                         r_done;

  logic              w_req;
  logic              w_beat;
  logic              w_last;
  logic [ADDR_W-1:0] w_off;

  assign w_req  = (r_state == S_IDLE) &
                  (bus.cl_read | bus.cl_write);
  assign w_beat = (r_state != S_IDLE) & bus.m_ack;
  assign w_last = w_beat & (r_cnt == LAST);
  assign w_off  = ADDR_W'(r_cnt) << BSH;

  assign bus.c_line_o = r_line;
  assign bus.cl_done  = r_done;

  // Next state and beat outputs, purely from the current state so that
  // an asynchronous reset drops the strobes without waiting for a clock.
  always_comb begin
    w_next      = r_state;
    bus.m_we    = 1'b0;
    bus.m_re    = 1'b0;
    bus.cl_busy = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cl_write) begin
          w_next = S_WRITE;
        end else if (bus.cl_read) begin
          w_next = S_READ;
        end
      end
      S_WRITE: begin
        bus.m_we    = 1'b1;
        bus.cl_busy = 1'b1;
        bus.m_addr  = r_wb_base + w_off;
        bus.m_wdata = r_wbuf[r_cnt];
        if (w_last) begin
          w_next = r_pend ? S_READ : S_IDLE;
        end
      end
      S_READ: begin
        bus.m_re    = 1'b1;
        bus.cl_busy = 1'b1;
        bus.m_addr  = r_rd_base + w_off;
        if (w_last) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, beat counting, fill assembly and the done pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wbuf    <= '0;
      r_line    <= '0;
      r_wb_base <= '0;
      r_rd_base <= '0;
      r_pend    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last &
                 ((r_state == S_READ) | ~r_pend);
      if (w_req) begin
        r_wbuf    <= bus.c_line_i;
        r_wb_base <= bus.wb_addr & MASK;
        r_rd_base <= bus.addr & MASK;
        r_pend    <= bus.cl_read & bus.cl_write;
        r_cnt     <= '0;
      end else if (w_beat) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        if (r_state == S_READ) begin
          r_line[r_cnt] <= bus.m_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_line_burst_adapter.sv
// Randomised scoreboard bench for the line/word burst adapter, covering
// the default geometry and a 64-bit x 4-word instance.
module tb_cache_line_burst_adapter;
  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [63:0] d;
  } beat_t;

  localparam logic [31:0] M = 32'hFFFF_FFE0;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  cache_line_burst_adapter_if #(
    .WORD_W(32), .WORDS(8), .ADDR_W(32)
  ) ia ();
  cache_line_burst_adapter_if #(
    .WORD_W(64), .WORDS(4), .ADDR_W(32)
  ) ib ();

  cache_line_burst_adapter #(
    .WORD_W(32), .WORDS(8), .ADDR_W(32)
  ) u_a (.CLK(CLK), .RST_N(RST_N), .bus(ia.slave));

  cache_line_burst_adapter #(
    .WORD_W(64), .WORDS(4), .ADDR_W(32)
  ) u_b (.CLK(CLK), .RST_N(RST_N), .bus(ib.slave));

  int vec = 0;
  int err = 0;
  bit pat = 1'b0;
  beat_t qa[$];
  beat_t qb[$];
  logic [255:0] la[$];
  logic [255:0] lb[$];
  logic [255:0] ela = '0;
  logic [255:0] elb = '0;

  function automatic logic [31:0] rdA(input logic [31:0] a,
                                      input bit p);
    return p ? 32'hA0 + {29'd0, a[4:2]}
             : (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [63:0] rdB(input logic [31:0] a);
    return {~a, a ^ 32'hDEAD_BEEF};
  endfunction

  always_comb ia.m_rdata = rdA(ia.m_addr, pat);
  always_comb ib.m_rdata = rdB(ib.m_addr);

  task automatic chk(input string n, input logic [255:0] a,
                     input logic [255:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  // Monitor for the 32x8 instance: every busy cycle is compared
  // against the head beat, which is retired on ack.
  always @(negedge CLK) begin
    #1;
    if (RST_N) begin
      chk("a_excl", 256'(ia.m_we & ia.m_re), 256'(0));
      if (ia.m_we || ia.m_re) begin
        if (qa.size() == 0) begin
          vec++;
          err++;
          $display("FAIL a_extra_beat got=%0h want=none",
                   ia.m_addr);
        end else begin
          chk("a_addr", 256'(ia.m_addr), 256'(qa[0].a));
          chk("a_we", 256'(ia.m_we), 256'(qa[0].we));
          chk("a_wdata", 256'(ia.m_wdata),
              256'(qa[0].d[31:0]));
          if (ia.m_ack) void'(qa.pop_front());
        end
      end
      if (ia.cl_done) begin
        if (la.size() == 0) begin
          vec++;
          err++;
          $display("FAIL a_extra_done got=1 want=0");
        end else begin
          chk("a_line", ia.c_line_o, la.pop_front());
        end
      end
    end
  end

  // Monitor for the 64x4 instance.
  always @(negedge CLK) begin
    #1;
    if (RST_N) begin
      chk("b_excl", 256'(ib.m_we & ib.m_re), 256'(0));
      if (ib.m_we || ib.m_re) begin
        if (qb.size() == 0) begin
          vec++;
          err++;
          $display("FAIL b_extra_beat got=%0h want=none",
                   ib.m_addr);
        end else begin
          chk("b_addr", 256'(ib.m_addr), 256'(qb[0].a));
          chk("b_we", 256'(ib.m_we), 256'(qb[0].we));
          chk("b_wdata", 256'(ib.m_wdata), 256'(qb[0].d));
          if (ib.m_ack) void'(qb.pop_front());
        end
      end
      if (ib.cl_done) begin
        if (lb.size() == 0) begin
          vec++;
          err++;
          $display("FAIL b_extra_done got=1 want=0");
        end else begin
          chk("b_line", ib.c_line_o, lb.pop_front());
        end
      end
    end
  end

  // mode: 0 ack always, 1 ack 0,1,0,1..., 2 random ack.
  // poke_c: cycle to pulse cl_write while busy; rst_acks: reset
  // after that many acks.
  task automatic run_req(input bit sel, input bit rd, input bit wr,
                         input logic [31:0] ra,
                         input logic [31:0] wa,
                         input logic [255:0] line,
                         input int mode, input int poke_c,
                         input int rst_acks);
    int nb;
    int acks;
    int dc;
    bit fin;
    logic ack;
    logic busy;
    logic done;
    logic [31:0] rb;
    logic [31:0] wb;
    rb = ra & M;
    wb = wa & M;
    nb = 0;
    if (!sel) begin
      if (wr) begin
        for (int k = 0; k < 8; k++)
          qa.push_back('{a: wb + 32'(4 * k), we: 1'b1,
                         d: {32'd0, line[k*32 +: 32]}});
        nb += 8;
      end
      if (rd) begin
        for (int k = 0; k < 8; k++) begin
          qa.push_back('{a: rb + 32'(4 * k), we: 1'b0,
                         d: 64'd0});
          ela[k*32 +: 32] = rdA(rb + 32'(4 * k), pat);
        end
        nb += 8;
      end
      la.push_back(ela);
    end else begin
      for (int k = 0; k < 4; k++) begin
        qb.push_back('{a: rb + 32'(8 * k), we: 1'b0,
                       d: 64'd0});
        elb[k*64 +: 64] = rdB(rb + 32'(8 * k));
      end
      nb = 4;
      lb.push_back(elb);
    end
    @(negedge CLK);
    if (!sel) begin
      ia.addr = ra;
      ia.wb_addr = wa;
      ia.c_line_i = line;
      ia.cl_read = rd;
      ia.cl_write = wr;
    end else begin
      ib.addr = ra;
      ib.wb_addr = wa;
      ib.c_line_i = line;
      ib.cl_read = 1'b1;
      ib.cl_write = 1'b0;
    end
    acks = 0;
    dc = -1;
    fin = 1'b0;
    for (int c = 1; c <= 4 * nb + 8; c++) begin
      @(negedge CLK);
      if (mode == 0) ack = 1'b1;
      else if (mode == 1) ack = (c % 2 == 0);
      else ack = 1'($urandom_range(0, 1));
      if (!sel) begin
        ia.m_ack = ack;
        ia.cl_read = 1'b0;
        ia.cl_write = (c == poke_c);
        ia.addr = $urandom;
        ia.wb_addr = $urandom;
        ia.c_line_i = {8{$urandom}};
      end else begin
        ib.m_ack = ack;
        ib.cl_read = 1'b0;
        ib.addr = $urandom;
        ib.wb_addr = $urandom;
        ib.c_line_i = {8{$urandom}};
      end
      #1;
      busy = sel ? ib.cl_busy : ia.cl_busy;
      done = sel ? ib.cl_done : ia.cl_done;
      chk("busy", 256'(busy), 256'(acks < nb));
      chk("done", 256'(done), 256'(c == dc));
      if (acks < nb && ack) begin
        acks++;
        if (acks == nb) dc = c + 1;
      end
      if (rst_acks > 0 && acks == rst_acks) begin
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_re", 256'(ia.m_re), 256'(0));
        chk("rst_we", 256'(ia.m_we), 256'(0));
        chk("rst_busy", 256'(ia.cl_busy), 256'(0));
        chk("rst_done", 256'(ia.cl_done), 256'(0));
        chk("rst_line", ia.c_line_o, 256'(0));
        qa.delete();
        la.delete();
        ela = '0;
        elb = '0;
        @(negedge CLK);
        ia.m_ack = 1'b0;
        RST_N = 1'b1;
        return;
      end
      if (dc > 0 && c == dc + 1) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) begin
      vec++;
      err++;
      $display("FAIL timeout got=%0d acks want=%0d", acks, nb);
      qa.delete();
      qb.delete();
      la.delete();
      lb.delete();
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    logic [255:0] l2;
    bit rd;
    bit wr;
    ia.addr = '0; ia.wb_addr = '0; ia.c_line_i = '0;
    ia.cl_read = 1'b0; ia.cl_write = 1'b0; ia.m_ack = 1'b0;
    ib.addr = '0; ib.wb_addr = '0; ib.c_line_i = '0;
    ib.cl_read = 1'b0; ib.cl_write = 1'b0; ib.m_ack = 1'b0;
    repeat (3) @(negedge CLK);
    chk("r_we", 256'(ia.m_we), 256'(0));
    chk("r_re", 256'(ia.m_re), 256'(0));
    chk("r_busy", 256'(ia.cl_busy), 256'(0));
    chk("r_done", 256'(ia.cl_done), 256'(0));
    chk("r_line", ia.c_line_o, 256'(0));
    chk("r_b_line", ib.c_line_o, 256'(0));
    RST_N = 1'b1;

    pat = 1'b1;
    run_req(0, 1, 0, 32'h1000_0014, 32'h0, '0, 0, 0, 0);
    chk("t1_w0", 256'(ia.c_line_o[31:0]), 256'(32'hA0));
    chk("t1_w7", 256'(ia.c_line_o[255:224]), 256'(32'hA7));
    pat = 1'b0;

    for (int k = 0; k < 8; k++)
      l2[k*32 +: 32] = 32'h1111_1111 * 32'(k);
    run_req(0, 0, 1, 32'h0, 32'h2000, l2, 1, 0, 0);
    chk("t2_keep", ia.c_line_o, ela);

    run_req(0, 1, 1, 32'h3000, 32'h2000, {8{$urandom}},
            0, 0, 0);
    run_req(0, 1, 0, 32'h5000, 32'h0, '0, 2, 3, 0);
    run_req(0, 1, 0, 32'h6000, 32'h0, '0, 0, 0, 3);
    run_req(0, 1, 0, 32'h4000, 32'h0, '0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      run_req(0, rd, wr, $urandom, $urandom, {8{$urandom}},
              2, (i % 3 == 0) ? 4 : 0, 0);
    end

    run_req(1, 1, 0, 32'hFFFF_FFE8, 32'h0, '0, 0, 0, 0);
    chk("t6_w0", 256'(ib.c_line_o[63:0]),
        256'(rdB(32'hFFFF_FFE0)));
    chk("t6_w3", 256'(ib.c_line_o[255:192]),
        256'(rdB(32'hFFFF_FFF8)));
    for (int i = 0; i < 4; i++)
      run_req(1, 1, 0, $urandom, 32'h0, '0, 2, 0, 0);

    repeat (3) @(negedge CLK);
    chk("qa_empty", 256'(qa.size()), 256'(0));
    chk("qb_empty", 256'(qb.size()), 256'(0));
    chk("la_empty", 256'(la.size()), 256'(0));
    chk("lb_empty", 256'(lb.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, err);
    $finish;
  end
endmodule

// File: doc/cache_line_burst_adapter.md
Name: cache_line_burst_adapter

Overview:
- Parametrised line-to-word bridge between an L1 cache controller and word-wide main memory.
- Serialises cache-line writebacks and deserialises line fills as bursts of word beats, with a per-beat ack handshake that allows memory wait states.
- Adds a combined writeback-then-fill mode for dirty evictions.
- Sits between the cache FSM and the memory arbiter.

Parameters:
WORD_W, 32, memory word width in bits (power of 2, >=8)
WORDS, 8, words per cache line (power of 2, >=2)
ADDR_W, 32, byte-address width
(derived) LINE_W = WORD_W*WORDS; BYTES = WORD_W/8; OFF = log2(WORDS*BYTES); CNT_W = max(1, log2(WORDS))

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
addr  in  ADDR_W  fill (read) line address; low OFF bits ignored
wb_addr  in  ADDR_W  writeback line address; low OFF bits ignored
c_line_i  in  LINE_W  line to write back; word k at bits [k*WORD_W +: WORD_W]
cl_read  in  1  fill request
cl_write  in  1  writeback request
m_rdata  in  WORD_W  memory read data, sampled on the ack cycle
m_ack  in  1  memory accepts the current beat this cycle
m_addr  out  ADDR_W  byte address of the current beat
m_wdata  out  WORD_W  write data of the current beat
m_we  out  1  write beat strobe
m_re  out  1  read beat strobe
c_line_o  out  LINE_W  filled line; same word packing as c_line_i
cl_busy  out  1  high while in WRITE or READ
cl_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, RST_N=0): state IDLE, beat counter 0, write buffer 0, c_line_o 0, cl_done 0. m_we, m_re and cl_busy go to 0 immediately without waiting for a clock edge.
  - Reset mid-burst discards all partial data. No beat is completed after reset asserts.
- States:
  - IDLE → WRITE on cl_write.
  - IDLE → READ on cl_read with cl_write=0.
  - WRITE → READ after the last write beat, if a fill is pending; otherwise WRITE → IDLE.
  - READ → IDLE after the last read beat.
- Request capture, in IDLE on the clock edge when cl_read or cl_write is high:
  - Latch c_line_i into the write buffer.
  - Latch wb_addr and addr with their low OFF bits zeroed.
  - Set the pending-fill flag = cl_read & cl_write.
  - Clear the counter.
- Requests while cl_busy=1 are ignored; they are neither queued nor able to corrupt latched state.
- Simultaneous cl_read and cl_write: the writeback runs first, using wb_addr. The fill then runs using addr. One cl_done pulse is issued, at the end of the fill only.
- Beat k (k = 0..WORDS-1, ascending):
  - m_addr = base + k*BYTES, computed modulo 2^ADDR_W.
  - In WRITE: m_wdata = write buffer word k.
  - In READ: m_wdata = 0.
- m_we is high in every WRITE cycle; m_re is high in every READ cycle. They are never high together.
- m_addr and m_wdata are held stable until m_ack. A beat completes on a cycle with m_ack=1, and the counter then advances.
- READ: on the ack of beat k, m_rdata is stored into c_line_o word k. Other words keep their value. c_line_o changes only on read acks, and is valid from the cl_done cycle until the next fill starts.
- Last beat (counter = WORDS-1, ack): the counter returns to 0 and the state leaves WRITE or READ on that edge.
- m_ack while in IDLE is ignored.
- cl_done is registered: high exactly one cycle, the first IDLE cycle after the final beat. cl_busy is 0 in that cycle, so a new request may be presented in the same cycle.
- Latency with m_ack held at 1, request sampled at edge 0:
  - Writeback or fill: beats occupy cycles 1..WORDS; cl_done in cycle WORDS+1.
  - Combined mode: 2*WORDS beat cycles with no idle gap between the two bursts; cl_done in cycle 2*WORDS+1.
- Each wait cycle (m_ack=0) extends latency by exactly one cycle.

Test Plan:
1. Fill, defaults, m_ack=1. addr=0x1000_0014, m_rdata = 0xA0+k on beat k. Expect m_addr 0x1000_0000, 0x1000_0004 … 0x1000_001C; m_re high for 8 cycles; cl_done in cycle 9; c_line_o[31:0]=0xA0 and c_line_o[255:224]=0xA7.
2. Writeback with wait states. wb_addr=0x2000, c_line_i word k = 0x1111_1111*k, m_ack toggling 0,1,0,1. Expect each m_wdata/m_addr pair held for 2 cycles; 8 beats at 0x2000..0x201C; cl_done in cycle 17; m_re never high.
3. Combined mode. wb_addr=0x2000, addr=0x3000, m_ack=1. Expect 8 m_we beats to 0x2000..0x201C, then in cycle 9 the first m_re beat at 0x3000; a single cl_done in cycle 17; cl_busy high for cycles 1–16.
4. Busy-ignore. During a fill, pulse cl_write with new wb_addr and c_line_i. Expect no m_we, the fill addresses unchanged, and exactly one cl_done.
5. Reset mid-fill. After 3 read acks, drop RST_N between clock edges. Expect m_re and cl_busy low immediately and c_line_o=0. After release, a new fill at 0x4000 completes normally starting at beat 0.
6. Parameter sweep, WORD_W=64, WORDS=4. addr=0xFFFF_FFE8 fill. Expect m_addr 0xFFFF_FFE0, FFE8, FFF0, FFF8; cl_done in cycle 5; c_line_o 256 bits correctly packed.
